// File: rtl/map_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// map_port_arbiter_if
// Groups the requester-side read bus and the map ROM port A signals that
// surround map_port_arbiter.
//
//   slave  modport : the arbiter (samples requests and map_data, drives grants,
//                    responses, the map address and busy)
//   master modport : the environment (requesters plus the map ROM port A)
//
// Signals:
//   req          requester read request, level-held until granted
//   req_col/row  per-requester address, requester i uses slice [i*W +: W]
//   gnt          one-cycle grant pulse, one-hot or zero
//   rsp_valid    one-cycle response strobe, one-hot or zero
//   rsp_data     registered pixel value, held between strobes
//   map_col_addr / map_row_addr  registered address to map port A
//   map_data     map port A read data
//   busy         high while any grant or read is in flight
//
// Handshake: a requester holds req (and its address) until it sees gnt[i];
// in that cycle it must drop req or present its next address. There is no
// response backpressure: rsp_valid is always accepted.
// -----------------------------------------------------------------------------
interface map_port_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int COL_W   = 10,
   parameter int ROW_W   = 10,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*COL_W-1:0] req_col;
   logic [NUM_REQ*ROW_W-1:0] req_row;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [DATA_W-1:0]        rsp_data;
   logic [COL_W-1:0]         map_col_addr;
   logic [ROW_W-1:0]         map_row_addr;
   logic [DATA_W-1:0]        map_data;
   logic                     busy;

   modport slave (
      input  req, req_col, req_row, map_data,
      output gnt, rsp_valid, rsp_data, map_col_addr, map_row_addr, busy
   );

   modport master (
      output req, req_col, req_row, map_data,
      input  gnt, rsp_valid, rsp_data, map_col_addr, map_row_addr, busy
   );
endinterface

// File: rtl/map_port_arbiter.sv
// -----------------------------------------------------------------------------
// map_port_arbiter
// Shares the map ROM collision read port between NUM_REQ requesters. A
// round-robin arbiter issues at most one read per cycle onto map port A, and a
// tag pipeline matched to the ROM latency steers each returned pixel back to
// the requester that issued it with a one-cycle rsp_valid strobe.
//
// Ports:
//   clk     single clock
//   reset   synchronous, active-high; discards reads in flight
//   io_bus  map_port_arbiter_if.slave (requests, grants, responses, map port A)
//
// Timing: request sampled at t, gnt and map address at t+1, map_data at
// t+1+READ_LATENCY, rsp_valid/rsp_data at t+2+READ_LATENCY.
// -----------------------------------------------------------------------------
module map_port_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int READ_LATENCY = 2,
   parameter int COL_W        = 10,
   parameter int ROW_W        = 10,
   parameter int DATA_W       = 8
) (
   input logic               clk,
   input logic               reset,
   map_port_arbiter_if.slave io_bus
);
   localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
   // One stage per cycle from the grant up to the cycle map_data is valid.
   localparam int NSTG  = READ_LATENCY + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_data;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [IDX_W-1:0]   r_last_gnt;
   logic [NSTG-1:0]    r_stg_valid;
   logic [IDX_W-1:0]   r_stg_idx [NSTG];

   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_gnt_next;
   logic [IDX_W-1:0]   w_winner;
   logic [IDX_W-1:0]   w_cand;
   logic               w_any;

   // A requester being granted this cycle is excluded so a level-held req is
   // not counted twice for the same address.
   always_comb begin
      w_elig     = io_bus.req & ~r_gnt;
      w_any      = 1'b0;
      w_winner   = r_last_gnt;
      w_cand     = r_last_gnt;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(r_last_gnt) + k) % NUM_REQ);
         if (!w_any && w_elig[w_cand]) begin
            w_any    = 1'b1;
            w_winner = w_cand;
         end
      end
      w_gnt_next = w_any ? (NUM_REQ'(1) << w_winner) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_last_gnt  <= LAST_IDX;
         r_stg_valid <= '0;
         for (int s = 0; s < NSTG; s++) begin
            r_stg_idx[s] <= '0;
         end
      end else begin
         r_gnt <= w_gnt_next;
         if (w_any) begin
            r_last_gnt <= w_winner;
            r_col      <= io_bus.req_col[w_winner*COL_W +: COL_W];
            r_row      <= io_bus.req_row[w_winner*ROW_W +: ROW_W];
         end
         // Stage 0 loads alongside the grant register, so the final stage is
         // valid in exactly the cycle the ROM presents the matching data.
         r_stg_valid  <= {r_stg_valid[NSTG-2:0], w_any};
         r_stg_idx[0] <= w_winner;
         for (int s = 1; s < NSTG; s++) begin
            r_stg_idx[s] <= r_stg_idx[s-1];
         end
         if (r_stg_valid[NSTG-1]) begin
            r_rsp_valid <= NUM_REQ'(1) << r_stg_idx[NSTG-1];
            r_rsp_data  <= io_bus.map_data;
         end else begin
            r_rsp_valid <= '0;
         end
      end
   end

   assign io_bus.gnt          = r_gnt;
   assign io_bus.rsp_valid    = r_rsp_valid;
   assign io_bus.rsp_data     = r_rsp_data;
   assign io_bus.map_col_addr = r_col;
   assign io_bus.map_row_addr = r_row;
   assign io_bus.busy         = (|r_gnt) | (|r_stg_valid) | (|r_rsp_valid);

endmodule

// File: tb/tb_map_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_map_port_arbiter
// Drives map_port_arbiter through its interface, models the map ROM with a
// READ_LATENCY-deep pipeline, and predicts every output from a reference
// model built on a queue of outstanding reads with their due cycles.
// -----------------------------------------------------------------------------
module tb_map_port_arbiter;
   localparam int N  = 2;
   localparam int RL = 2;
   localparam int CW = 10;
   localparam int RW = 10;
   localparam int DW = 8;

   logic clk;
   logic reset;

   map_port_arbiter_if #(.NUM_REQ(N), .COL_W(CW), .ROW_W(RW), .DATA_W(DW)) bus ();

   map_port_arbiter #(
      .NUM_REQ(N), .READ_LATENCY(RL), .COL_W(CW), .ROW_W(RW), .DATA_W(DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io_bus(bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- map ROM model ----------------
   function automatic logic [DW-1:0] rom(input logic [CW-1:0] c, input logic [RW-1:0] r);
      return c[7:0] ^ r[7:0] ^ {c[9:8], r[9:8], 4'h0} ^ 8'h57;
   endfunction

   logic [DW-1:0] rom_pipe [RL];
   always @(posedge clk) begin
      rom_pipe[0] <= rom(bus.map_col_addr, bus.map_row_addr);
      for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
   end
   assign bus.map_data = rom_pipe[RL-1];

   // ---------------- reference model ----------------
   int            cyc;
   int            n_cmp;
   int            n_bad;
   int            m_last;
   logic [N-1:0]  m_gnt;
   logic [N-1:0]  m_rsp_valid;
   logic [DW-1:0] m_rsp_data;
   logic [CW-1:0] m_col;
   logic [RW-1:0] m_row;
   logic          m_busy;
   logic [DW+1:0] exp_q[$];   // {requester index, expected pixel}
   int            due_q[$];   // cycle at which the response must appear

   function automatic logic [32:0] dut_vec();
      return {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.map_col_addr, bus.map_row_addr, bus.busy};
   endfunction

   function automatic logic [32:0] exp_vec();
      return {m_gnt, m_rsp_valid, m_rsp_data, m_col, m_row, m_busy};
   endfunction

   // Advance one clock and update the model with the inputs that edge sampled.
   task automatic tick();
      logic [N-1:0]  elig;
      logic [N-1:0]  ng;
      logic [DW+1:0] ent;
      int            c;
      int            d;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         m_last      = N - 1;
         m_gnt       = '0;
         m_rsp_valid = '0;
         m_rsp_data  = '0;
         m_col       = '0;
         m_row       = '0;
         exp_q.delete();
         due_q.delete();
      end else begin
         m_rsp_valid = '0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            ent         = exp_q.pop_front();
            d           = due_q.pop_front();
            m_rsp_valid = N'(1) << ent[DW+1:DW];
            m_rsp_data  = ent[DW-1:0];
         end
         elig = bus.req & ~m_gnt;
         ng   = '0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (ng == '0 && elig[c]) begin
               ng[c]  = 1'b1;
               m_last = c;
               m_col  = bus.req_col[c*CW +: CW];
               m_row  = bus.req_row[c*RW +: RW];
               exp_q.push_back({2'(c), rom(m_col, m_row)});
               due_q.push_back(cyc + RL + 1);
            end
         end
         m_gnt = ng;
      end
      m_busy = (m_gnt != '0) || (due_q.size() != 0) || (m_rsp_valid != '0);
   endtask

   task automatic set_req(input int i, input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r);
      bus.req[i]               = v;
      bus.req_col[i*CW +: CW]  = c;
      bus.req_row[i*RW +: RW]  = r;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset       = 1'b1;
      bus.req     = '1;
      bus.req_col = (N*CW)'($urandom);
      bus.req_row = (N*RW)'($urandom);
      repeat (3) begin
         tick();
         n_cmp++;
         if (dut_vec() !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, dut_vec());
         end
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (bus.gnt !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_first_grant cyc=%0d got=%b exp=01", cyc, bus.gnt);
      end
      bus.req = '0;
      repeat (6) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single_read();
      set_req(0, 1'b1, 10'h20F, 10'h0FE);
      set_req(1, 1'b0, 10'h000, 10'h000);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) bus.req = '0;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.gnt !== 2'b01 || bus.map_col_addr !== 10'h20F || bus.map_row_addr !== 10'h0FE) begin
               n_bad++;
               $display("FAIL single_grant got gnt=%b col=%h row=%h exp gnt=01 col=20f row=0fe",
                        bus.gnt, bus.map_col_addr, bus.map_row_addr);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h26) begin
               n_bad++;
               $display("FAIL single_rsp got valid=%b data=%h exp valid=01 data=26",
                        bus.rsp_valid, bus.rsp_data);
            end
         end
         n_cmp++;
         if (bus.rsp_valid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rsp1_quiet cyc=%0d got=%b exp=0", cyc, bus.rsp_valid[1]);
         end
      end
   endtask

   task automatic test_contention();
      int prev;
      int idx;
      prev = -1;
      set_req(0, 1'b1, CW'($urandom), RW'($urandom));
      set_req(1, 1'b1, CW'($urandom), RW'($urandom));
      for (int k = 1; k <= 28; k++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL contention_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         if (k <= 20) begin
            idx = bus.gnt[1] ? 1 : 0;
            n_cmp++;
            if (!$onehot(bus.gnt) || (prev >= 0 && idx == prev)) begin
               n_bad++;
               $display("FAIL contention_alternate cyc=%0d got gnt=%b prev=%0d exp one-hot other than prev",
                        cyc, bus.gnt, prev);
            end
            prev = idx;
         end
         for (int i = 0; i < N; i++) begin
            if (k >= 20) bus.req[i] = 1'b0;
            else if (bus.gnt[i]) set_req(i, 1'b1, CW'($urandom), RW'($urandom));
         end
      end
   endtask

   task automatic test_pipelined();
      logic [CW-1:0] ca, cb;
      logic [RW-1:0] ra, rb;
      ca = 10'h123; ra = 10'h045;
      cb = 10'h3A1; rb = 10'h2DC;
      set_req(0, 1'b1, ca, ra);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) begin bus.req[0] = 1'b0; set_req(1, 1'b1, cb, rb); end
         if (k == 2) bus.req = '0;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL pipe_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         if (k == 2) begin
            n_cmp++;
            if (bus.gnt !== 2'b10 || bus.map_col_addr !== cb) begin
               n_bad++;
               $display("FAIL pipe_grant1 got gnt=%b col=%h exp gnt=10 col=%h", bus.gnt, bus.map_col_addr, cb);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== rom(ca, ra)) begin
               n_bad++;
               $display("FAIL pipe_rsp0 got valid=%b data=%h exp valid=01 data=%h",
                        bus.rsp_valid, bus.rsp_data, rom(ca, ra));
            end
         end
         if (k == 5) begin
            n_cmp++;
            if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== rom(cb, rb)) begin
               n_bad++;
               $display("FAIL pipe_rsp1 got valid=%b data=%h exp valid=10 data=%h",
                        bus.rsp_valid, bus.rsp_data, rom(cb, rb));
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      set_req(0, 1'b1, 10'h0AA, 10'h155);
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) bus.req = '0;
         if (k == 2) reset = 1'b1;
         if (k == 3) reset = 1'b0;
         if (k == 6) set_req(1, 1'b1, 10'h301, 10'h077);
         if (k == 7) bus.req = '0;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         if (k == 3) begin
            n_cmp++;
            if (bus.busy !== 1'b0) begin
               n_bad++;
               $display("FAIL midreset_busy got=%b exp=0", bus.busy);
            end
         end
         if (k >= 3 && k <= 7) begin
            n_cmp++;
            if (bus.rsp_valid !== 2'b00) begin
               n_bad++;
               $display("FAIL midreset_no_rsp cyc=%0d got=%b exp=00", cyc, bus.rsp_valid);
            end
         end
         if (k == 7) begin
            n_cmp++;
            if (bus.gnt !== 2'b10) begin
               n_bad++;
               $display("FAIL midreset_fresh_grant got=%b exp=10", bus.gnt);
            end
         end
      end
   endtask

   task automatic test_hold_repeat();
      int n_rsp;
      logic [DW-1:0] want;
      n_rsp = 0;
      want  = rom(10'h1C3, 10'h2B0);
      set_req(0, 1'b1, 10'h1C3, 10'h2B0);
      set_req(1, 1'b0, 10'h000, 10'h000);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 6) bus.req = '0;
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL hold_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         if (k <= 6) begin
            n_cmp++;
            if (bus.gnt !== ((k % 2 == 1) ? 2'b01 : 2'b00)) begin
               n_bad++;
               $display("FAIL hold_grant_pattern k=%0d got=%b exp=%b", k, bus.gnt,
                        (k % 2 == 1) ? 2'b01 : 2'b00);
            end
         end
         if (bus.rsp_valid[0]) begin
            n_rsp++;
            n_cmp++;
            if (bus.rsp_data !== want) begin
               n_bad++;
               $display("FAIL hold_rsp_data got=%h exp=%h", bus.rsp_data, want);
            end
         end
      end
      n_cmp++;
      if (n_rsp != 3) begin
         n_bad++;
         $display("FAIL hold_rsp_count got=%0d exp=3", n_rsp);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
         end
         n_cmp++;
         if (!$onehot0(bus.gnt) || !$onehot0(bus.rsp_valid)) begin
            n_bad++;
            $display("FAIL random_onehot cyc=%0d got gnt=%b rsp=%b exp one-hot or zero",
                     cyc, bus.gnt, bus.rsp_valid);
         end
         reset = (k < 390) && ($urandom_range(0, 49) == 0);
         for (int i = 0; i < N; i++) begin
            if (k >= 390) bus.req[i] = 1'b0;
            else if (!(bus.req[i] && !bus.gnt[i])) begin
               if ($urandom_range(0, 2) != 0) set_req(i, 1'b1, CW'($urandom), RW'($urandom));
               else bus.req[i] = 1'b0;
            end
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      cyc         = 0;
      n_cmp       = 0;
      n_bad       = 0;
      m_last      = N - 1;
      m_gnt       = '0;
      m_rsp_valid = '0;
      m_rsp_data  = '0;
      m_col       = '0;
      m_row       = '0;
      m_busy      = 1'b0;
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_col = '0;
      bus.req_row = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_pipelined();
      test_reset_midflight();
      test_hold_repeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/map_port_arbiter.md
# map_port_arbiter

Shares the map ROM's collision read port between several requesters, such as the ball collision scanner and a goal/hole detector. Requesters post pixel-address reads, and a round-robin arbiter issues at most one read per cycle onto the map port. A latency-matched tag pipeline returns each result to its owner with a one-cycle valid strobe. The block sits between the requesters and the map block's port A (col/row address in, 8-bit pixel out).

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- READ_LATENCY, 2: map port latency in cycles, from address presented to map_data valid (1..4).
- COL_W, 10: column address width.
- ROW_W, 10: row address width.
- DATA_W, 8: pixel width.

Ports:
- clk, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: read request per requester; level-held until granted.
- req_col, input, NUM_REQ*COL_W: column address; requester i uses slice [i*COL_W +: COL_W].
- req_row, input, NUM_REQ*ROW_W: row address, sliced the same way.
- gnt, output, NUM_REQ: one-cycle grant pulse, one-hot or zero.
- rsp_valid, output, NUM_REQ: one-cycle response strobe, one-hot or zero.
- rsp_data, output, DATA_W: registered pixel value; holds its value between strobes.
- map_col_addr, output, COL_W: registered address to map port A.
- map_row_addr, output, ROW_W: registered address to map port A.
- map_data, input, DATA_W: map port A read data.
- busy, output, 1: high while any grant or read is in flight.

## Operation
- Eligible set: req[i] & ~gnt[i]. A request is never re-counted in its own grant cycle.
- Arbitration, every cycle the eligible set is non-empty:
  - Pick the first eligible index, scanning upward from last_gnt+1 mod NUM_REQ.
  - Register one-hot gnt, map_col_addr/map_row_addr ← the winner's slices, last_gnt ← winner.
- Empty eligible set: gnt=0; map addresses hold their last value; last_gnt unchanged.
- Requester handshake:
  - Requester must drop req, or present its next address, in the cycle it sees gnt[i].
  - req still high in the cycle after gnt is a new request. Best case is one read every 2 cycles per requester; the port can still take 1 read/cycle across requesters.
- Tag pipeline: READ_LATENCY+1 stages of {valid, index}, shifted every cycle. Stage 0 loads {|gnt, winner index}.
  - When the final stage is valid: rsp_data ← map_data, rsp_valid[index] ← 1 for one cycle.
- Responses return in issue order; there is no reordering and no backpressure. Requesters must always accept rsp_valid.
- busy = |gnt | any pipeline stage valid | |rsp_valid.
- Reset (any cycle, including mid-flight):
  - Cleared: all pipeline stages, gnt, rsp_valid, rsp_data, map_col_addr, map_row_addr, busy.
  - last_gnt ← NUM_REQ-1, so requester 0 wins first.
  - Reads in flight are discarded; no rsp_valid is produced for them.
- Out-of-range addresses pass through unchanged; range checking belongs to the requester.

## Timing
- Cycle t: req[i] sampled high and eligible.
- t+1: gnt[i]=1; map addresses driven.
- t+1+READ_LATENCY: map_data valid at the map port.
- t+2+READ_LATENCY: rsp_valid[i]=1, rsp_data valid. Request-to-response latency is READ_LATENCY+2.
- Simultaneous requests: granted on consecutive cycles in round-robin order; responses follow the same order.
- Sustained traffic: one read per cycle across requesters, one response per cycle.
- rsp_valid and gnt may be high in the same cycle for the same requester (new grant alongside an older response).

## Test plan
- Reset values: assert reset for 3 cycles while req=2'b11 -> gnt, rsp_valid, busy, map addresses all 0. First grant after release goes to requester 0 at the 2nd cycle after reset falls.
- Single read: READ_LATENCY=2, req[0] with col=0x20F, row=0x0FE, ROM model returning 0x26 there -> gnt[0] one cycle later with map_col_addr=0x20F, map_row_addr=0x0FE; rsp_valid[0] with rsp_data=0x26 exactly 4 cycles after req is sampled; rsp_valid[1] never high.
- Contention: both requesters hold req continuously (each re-arming the cycle after its grant) for 20 cycles -> grants strictly alternate 0,1,0,1; every gnt is one-hot; responses arrive in the same order with the correct per-address data.
- Pipelined throughput: req[0] at t, req[1] at t+1 (distinct addresses) -> grants at t+1 and t+2; responses at t+4 and t+5 with the matching data.
- Reset mid-flight: reset asserted 1 cycle after gnt[0] -> no rsp_valid at any point afterward; busy=0 the cycle after reset; a fresh req[1] after reset is granted normally.
- Hold-and-repeat: req[0] held high for 6 cycles with a fixed address -> gnt[0] at cycles 1, 3, 5, giving 3 responses with identical data and no grant in the same cycle as the previous one.
